// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard; r0 reads as zero.
// Latency: reads are combinational; writes and scoreboard updates land on the next rising edge.
// Backpressure: none. Every port is accepted every cycle. Optional write-first bypass: REGFILE_MP_BYPASS_EN.
module regfile_mp_sb #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  sb_set_en,
    input  logic [AW-1:0]         sb_set_addr,
    input  logic                  sb_flush,
    output logic [NREGS-1:0]      busy_vec
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Register array: ports are applied low to high, so the higher port wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    regs[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Scoreboard next state: writeback clears, then issue sets (a new producer wins), flush clears all.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set_en && (sb_set_addr != '0)) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        if (sb_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[p*AW +: AW];

        // Read mux: registered value, optionally overridden by a same-cycle write; r0 forced to zero.
        always_comb begin
            data = regs[addr];
`ifdef REGFILE_MP_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                    data = wr_data[w*DATA_W +: DATA_W];
                end
            end
`endif
            if (addr == '0) begin
                data = '0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        // Busy reports the registered scoreboard only; an issue in this cycle is not visible yet.
        assign rd_busy[p] = busy_q[addr] & (addr != '0);
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios followed by a randomized run against a reference model.
// Expected values are queued as stimulus is applied and compared once outputs settle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_regfile_mp_sb;

    localparam int NREGS  = 32;
    localparam int DATA_W = 32;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int AW     = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*DATA_W-1:0] wr_data;
    logic                  sb_set_en;
    logic [AW-1:0]         sb_set_addr;
    logic                  sb_flush;
    logic [NREGS-1:0]      busy_vec;

    regfile_mp_sb #(.NREGS(NREGS), .DATA_W(DATA_W), .NRD(NRD), .NWR(NWR)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    // kind: 0 = rd_data port0, 1 = rd_data port1, 2 = rd_busy, 3 = busy_vec
    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic [DATA_W-1:0] m_regs [NREGS];
    logic [NREGS-1:0]  m_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            0:       return 64'(rd_data[0 +: DATA_W]);
            1:       return 64'(rd_data[DATA_W +: DATA_W]);
            2:       return 64'(rd_busy);
            default: return 64'(busy_vec);
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        wr_en     = '0;
        sb_set_en = 1'b0;
        sb_flush  = 1'b0;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        wr_en[port]                    = 1'b1;
        wr_addr[port*AW +: AW]         = a;
        wr_data[port*DATA_W +: DATA_W] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic sb_set(input logic [AW-1:0] a);
        sb_set_en   = 1'b1;
        sb_set_addr = a;
    endtask

    task automatic model_eval(output logic [DATA_W-1:0] d0, output logic [DATA_W-1:0] d1,
                              output logic [1:0] b);
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] d;
        for (int p = 0; p < NRD; p++) begin
            a = rd_addr[p*AW +: AW];
            d = m_regs[a];
`ifdef REGFILE_MP_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == a) d = wr_data[w*DATA_W +: DATA_W];
            end
`endif
            if (a == 0) d = '0;
            b[p] = (a == 0) ? 1'b0 : m_busy[a];
            if (p == 0) d0 = d; else d1 = d;
        end
    endtask

    task automatic model_step();
        logic [AW-1:0] a;
        for (int w = 0; w < NWR; w++) begin
            a = wr_addr[w*AW +: AW];
            if (wr_en[w] && a != 0) m_regs[a] = wr_data[w*DATA_W +: DATA_W];
        end
        if (sb_flush) begin
            m_busy = '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w]) m_busy[wr_addr[w*AW +: AW]] = 1'b0;
            end
            if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
        end
        m_busy[0] = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] e0, e1;
        logic [1:0]        eb;

        reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; sb_flush = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        rd(5'd5, 5'd31);
        push("rst_r5", 0, 64'h0); push("rst_r31", 1, 64'h0); push("rst_busy", 3, 64'h0);
        drain();

        // Load r5 and mark it busy, then reset must clear both
        wr(0, 5'd5, 32'h5555_0005); sb_set(5'd5);
        nxt();
        rd(5'd5, 5'd0);
        push("pre_rst_r5", 0, 64'h5555_0005); push("pre_rst_busy", 2, 64'h1);
        drain();
        wr(1, 5'd6, 32'h66); reset = 1'b1;
        nxt(); nxt();
        reset = 1'b0;
        rd(5'd5, 5'd6);
        push("rst2_r5", 0, 64'h0); push("rst2_r6", 1, 64'h0); push("rst2_busy", 3, 64'h0);
        drain();

        // Basic write, then write to r0 is discarded
        wr(0, 5'd3, 32'hDEAD_BEEF);
        nxt();
        rd(5'd3, 5'd0);
        push("wr_r3", 0, 64'hDEAD_BEEF); push("rd_r0", 1, 64'h0);
        drain();
        wr(0, 5'd0, 32'h1234);
        nxt();
        rd(5'd0, 5'd3);
        push("r0_zero", 0, 64'h0); push("r3_keep", 1, 64'hDEAD_BEEF);
        drain();

        // Collision: higher port wins
        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
        nxt();
        rd(5'd7, 5'd7);
        push("coll_p0", 0, 64'h22); push("coll_p1", 1, 64'h22);
        drain();

        // Bypass vs read-first
        wr(0, 5'd9, 32'h0000_0009);
        nxt();
        wr(1, 5'd9, 32'hA5A5_A5A5); rd(5'd9, 5'd3);
`ifdef REGFILE_MP_BYPASS_EN
        push("byp_r9", 0, 64'hA5A5_A5A5);
`else
        push("byp_r9", 0, 64'h0000_0009);
`endif
        push("byp_r3", 1, 64'hDEAD_BEEF);
        drain();
        nxt();
        rd(5'd9, 5'd0);
        push("after_r9", 0, 64'hA5A5_A5A5);
        drain();

        // Scoreboard: set visible next cycle only; set beats same-cycle clear; clear alone
        sb_set(5'd4); rd(5'd4, 5'd0);
        push("sb_same_cyc", 2, 64'h0);
        drain();
        nxt();
        push("sb_set_rdb", 2, 64'h1); push("sb_set_vec", 3, 64'h10);
        drain();
        wr(0, 5'd4, 32'h44); sb_set(5'd4);
        nxt();
        push("sb_set_wins", 3, 64'h10);
        drain();
        wr(1, 5'd4, 32'h45);
        nxt();
        push("sb_clear", 3, 64'h0); push("sb_clr_data", 0, 64'h45);
        drain();
        sb_set(5'd0);
        nxt();
        push("sb_set_r0", 3, 64'h0);
        drain();

        // Flush: clears everything, ignores same-cycle set, writes still land
        sb_set(5'd2); nxt();
        sb_set(5'd6); nxt();
        push("pre_flush", 3, 64'h44);
        drain();
        sb_flush = 1'b1; sb_set(5'd8); wr(0, 5'd10, 32'h77);
        nxt();
        rd(5'd8, 5'd10);
        push("flush_vec", 3, 64'h0); push("flush_r8", 2, 64'h0); push("flush_wr", 1, 64'h77);
        drain();

        // Randomized run against the model, starting from reset
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
        m_busy = '0;
        for (int i = 0; i < 400; i++) begin
            wr_en = 2'($urandom_range(0, 3));
            for (int w = 0; w < NWR; w++) begin
                wr_addr[w*AW +: AW]         = 5'($urandom_range(0, 7));
                wr_data[w*DATA_W +: DATA_W] = $urandom;
            end
            sb_set_en   = 1'($urandom_range(0, 1));
            sb_set_addr = 5'($urandom_range(0, 7));
            sb_flush    = ($urandom_range(0, 15) == 0);
            rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            model_eval(e0, e1, eb);
            push("rnd_d0", 0, 64'(e0)); push("rnd_d1", 1, 64'(e1));
            push("rnd_busy", 2, 64'(eb)); push("rnd_vec", 3, 64'(m_busy));
            drain();
            model_step();
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
